serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing A - B LSB-first, one bit per clock, using a single-bit difference/borrow cell and a borrow flip-flop. It is the subtraction counterpart to the team's combinational adder cells, sized for area-constrained datapaths where latency is acceptable. Operands enter through a valid/ready start handshake. Results leave through a valid/ready done handshake.

---
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial unsigned subtractor: computes A - B LSB-first, one bit per clock,
// with a single difference/borrow cell and a borrow flip-flop.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   start_valid  operands A/B valid, request to start
//   start_ready  block idle, can accept operands
//   A, B         minuend / subtrahend, sampled on the start handshake
//   busy         high while bits are being processed
//   done_valid   diff/borrow valid
//   done_ready   consumer accepts the result
//   diff         A - B modulo 2^WIDTH
//   borrow       1 when A < B (unsigned)
//   ovf          signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN defined)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN adds the ovf output.
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             bin_q;
    logic [CntW-1:0]  cnt_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic a_msb_q;
    logic b_msb_q;
`endif

    // Single-bit difference/borrow cell on the current operand LSBs.
    logic             a0;
    logic             b0;
    logic             d;
    logic             bout;
    logic [WIDTH-1:0] diff_shift;

    always_comb begin
        a0   = a_sh_q[0];
        b0   = b_sh_q[0];
        d    = a0 ^ b0 ^ bin_q;
        bout = (~a0 & b0) | (~(a0 ^ b0) & bin_q);
        // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands at diff[0].
        diff_shift            = diff >> 1;
        diff_shift[WIDTH-1]   = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            bin_q       <= 1'b0;
            cnt_q       <= '0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            done_valid  <= 1'b0;
            diff        <= '0;
            borrow      <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf         <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        a_sh_q      <= A;
                        b_sh_q      <= B;
                        bin_q       <= 1'b0;
                        cnt_q       <= '0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state_q     <= StRun;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        a_msb_q     <= A[WIDTH-1];
                        b_msb_q     <= B[WIDTH-1];
`endif
                    end
                end
                StRun: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    diff   <= diff_shift;
                    bin_q  <= bout;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        borrow     <= bout;
                        busy       <= 1'b0;
                        done_valid <= 1'b1;
                        state_q    <= StDone;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        // d is the final diff MSB on this edge.
                        ovf        <= (a_msb_q != b_msb_q) && (d != a_msb_q);
`endif
                    end
                end
                StDone: begin
                    if (done_ready) begin
                        done_valid  <= 1'b0;
                        start_ready <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Self-checking bench for serial_subtractor at WIDTH = 1, 8 and 32. Expected
// results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    logic clk;
    logic rst_n;
    int   cyc = 0;

    logic       sv1, sr1, busy1, dv1, dr1, br1;
    logic [0:0] a1, b1, d1;
    logic       sv8, sr8, busy8, dv8, dr8, br8;
    logic [7:0] a8, b8, d8;
    logic        sv32, sr32, busy32, dv32, dr32, br32;
    logic [31:0] a32, b32, d32;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic ovf1, ovf8, ovf32;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1), .A(a1), .B(b1),
        .busy(busy1), .done_valid(dv1), .done_ready(dr1), .diff(d1), .borrow(br1)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_subtractor #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8), .A(a8), .B(b8),
        .busy(busy8), .done_valid(dv8), .done_ready(dr8), .diff(d8), .borrow(br8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv32), .start_ready(sr32), .A(a32), .B(b32),
        .busy(busy32), .done_valid(dv32), .done_ready(dr32), .diff(d32), .borrow(br32)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(ovf32)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- helpers
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input int w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    // Reference: unsigned modular difference.
    function automatic logic [31:0] mdiff(input int w, input logic [31:0] a, input logic [31:0] b);
        longint r;
        r = longint'(a) - longint'(b);
        if (r < 0) r = r + (longint'(1) << w);
        return 32'(r);
    endfunction

    // Reference: signed result falls outside the w-bit two's-complement range.
    function automatic logic movf(input int w, input logic [31:0] a, input logic [31:0] b);
        longint lim, sa, sb, sd;
        lim = longint'(1) << (w - 1);
        sa  = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
        sb  = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
        sd  = sa - sb;
        return (sd < -lim) || (sd >= lim);
    endfunction

    task automatic set_in(input int w, input logic sv, input logic [31:0] a, input logic [31:0] b,
                          input logic dr);
        case (w)
            1: begin sv1 = sv; a1 = a[0:0]; b1 = b[0:0]; dr1 = dr; end
            8: begin sv8 = sv; a8 = a[7:0]; b8 = b[7:0]; dr8 = dr; end
            default: begin sv32 = sv; a32 = a; b32 = b; dr32 = dr; end
        endcase
    endtask

    function automatic logic [31:0] get_diff(input int w);
        case (w)
            1: return {31'd0, d1};
            8: return {24'd0, d8};
            default: return d32;
        endcase
    endfunction

    // {start_ready, busy, done_valid, borrow, ovf}
    function automatic logic [4:0] status(input int w);
        logic [4:0] s;
        case (w)
            1: s = {sr1, busy1, dv1, br1, 1'b0};
            8: s = {sr8, busy8, dv8, br8, 1'b0};
            default: s = {sr32, busy32, dv32, br32, 1'b0};
        endcase
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        case (w)
            1: s[0] = ovf1;
            8: s[0] = ovf8;
            default: s[0] = ovf32;
        endcase
`endif
        return s;
    endfunction

    function automatic logic exp_ovf(input int w, input logic [31:0] a, input logic [31:0] b);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        return movf(w, a, b);
`else
        return 1'b0;
`endif
    endfunction

    // One full operation with done_ready held high. Called at a negedge with the
    // instance idle; returns at the negedge after the result is consumed.
    task automatic do_op(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                         output int t_acc);
        logic [31:0] a, b, ed;
        logic        eb, eo;
        int          n;
        a  = a_in & mask(w);
        b  = b_in & mask(w);
        ed = mdiff(w, a, b);
        eb = (a < b);
        eo = exp_ovf(w, a, b);
        set_in(w, 1'b1, a, b, 1'b1);
        @(negedge clk);
        set_in(w, 1'b0, a, b, 1'b1);
        t_acc = cyc;
        chk("accept_status", 64'(status(w) & 5'b11100), 64'(5'b01000));
        n = 0;
        while (!status(w)[2] && n < w + 4) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(w));
        chk("diff", 64'(get_diff(w)), 64'(ed));
        chk("done_status", 64'(status(w)), 64'({3'b001, eb, eo}));
        @(negedge clk);
        chk("return_idle", 64'(status(w) & 5'b11100), 64'(5'b10000));
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int          t, t_prev, w;
        logic [31:0] ra, rb, ed;
        logic        eb, eo;
        int          n;

        rst_n = 1'b0;
        set_in(1, 1'b0, 32'd0, 32'd0, 1'b0);
        set_in(8, 1'b0, 32'd0, 32'd0, 1'b0);
        set_in(32, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset_status_w8", 64'(status(8)), 64'(5'b10000));
        chk("reset_diff_w8", 64'(get_diff(8)), 64'd0);
        chk("reset_status_w32", 64'(status(32)), 64'(5'b10000));
        chk("reset_status_w1", 64'(status(1)), 64'(5'b10000));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations at WIDTH=8.
        do_op(8, 32'd200, 32'd55, t);
        do_op(8, 32'd55, 32'd200, t);
        do_op(8, 32'd0, 32'd1, t);
        do_op(8, 32'd0, 32'd0, t);
        do_op(8, 32'hFF, 32'hFF, t);
        do_op(8, 32'hFF, 32'h00, t);

        // Back-pressure: result held, stray start ignored.
        ra = 32'h3C; rb = 32'h5A;
        ed = mdiff(8, ra, rb);
        eb = (ra < rb);
        eo = exp_ovf(8, ra, rb);
        set_in(8, 1'b1, ra, rb, 1'b0);
        @(negedge clk);
        set_in(8, 1'b0, ra, rb, 1'b0);
        n = 0;
        while (!dv8 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 64'(n), 64'd8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_diff", 64'(d8), 64'(ed));
            chk("bp_hold_status", 64'(status(8)), 64'({3'b001, eb, eo}));
            if (i == 1) set_in(8, 1'b1, 32'h11, 32'h22, 1'b0);
            else set_in(8, 1'b0, 32'h11, 32'h22, 1'b0);
            @(negedge clk);
        end
        set_in(8, 1'b0, 32'h0, 32'h0, 1'b1);
        @(negedge clk);
        chk("bp_release_status", 64'(status(8)), 64'({3'b100, eb, eo}));
        chk("bp_release_diff", 64'(d8), 64'(ed));

        // Asynchronous reset in the middle of RUN (bits 0..2 already processed).
        set_in(8, 1'b1, 32'hF0, 32'h0F, 1'b1);
        @(negedge clk);
        set_in(8, 1'b0, 32'hF0, 32'h0F, 1'b1);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 64'(busy8), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_status", 64'(status(8)), 64'(5'b10000));
        chk("midrun_reset_diff", 64'(d8), 64'd0);
        @(negedge clk);
        chk("reset_held_status", 64'(status(8)), 64'(5'b10000));
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8, 32'h10, 32'h01, t);
        chk("post_reset_diff", 64'(d8), 64'h0F);

        // Signed-overflow corner cases (ovf checked when the feature is built in).
        do_op(8, 32'h80, 32'h01, t);
        do_op(8, 32'h7F, 32'hFF, t);
        do_op(8, 32'h05, 32'h03, t);

        // Random sweep, back-to-back, at each width.
        for (int wi = 0; wi < 3; wi++) begin
            w = (wi == 0) ? 1 : ((wi == 1) ? 8 : 32);
            t_prev = 0;
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i % 16 == 3) rb = ra;
                do_op(w, ra, rb, t);
                if (i > 0) chk("issue_interval", 64'(t - t_prev), 64'(w + 2));
                t_prev = t;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
